// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl : instruction-fetch sequencer
//   Owns the PC and issues at most one fetch per cycle to a synchronous ROM.
//   The response (one cycle later) goes into a small FIFO. Decode drains the
//   FIFO through a valid/ready handshake. The block also handles redirects,
//   halt requests and misaligned redirect targets.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   FIFO_DEPTH   instruction buffer entries (2..8)
//
// Ports
//   i_clk, i_rstn          clock, synchronous active-low reset
//   o_imem_req/o_imem_addr fetch request and its address (the PC register)
//   i_imem_rdata           ROM data, valid one cycle after o_imem_req
//   o_if_valid/i_if_ready  decode handshake
//   o_if_instr/o_if_pc     FIFO head instruction and its address (0 if empty)
//   i_redirect_valid/_pc   branch/jump redirect: flush and refetch
//   i_halt_req             level halt request
//   o_halted               in HALTED or ERROR (no fetch in flight)
//   o_misalign_err         sticky, set by a redirect target with pc[1:0]!=0
//
// Optional feature (macro FETCH_PERF_EN):
//   o_perf_fetched         counts FIFO pops
//   o_perf_stall           counts RUN cycles with no request and no halt
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt_req,
   output logic        o_halted,
   output logic        o_misalign_err
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_stall
`endif
);

   localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   localparam logic [1:0] S_BOOT   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;
   localparam logic [1:0] S_ERROR  = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [31:0]   r_pc;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;
   logic          r_misalign;

   logic [31:0]   r_mem_instr [FIFO_DEPTH];
   logic [31:0]   r_mem_pc    [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_valid;
   logic          w_pop;
   logic          w_fifo_pop;
   logic          w_push;
   logic          w_redirect;
   logic          w_misalign;
   logic          w_room;
   logic          w_req;
   logic [CW:0]   w_occ;
   logic [CW:0]   w_lim;

   function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid & i_if_ready;
   // ERROR ignores redirects entirely; it is left only through reset
   assign w_redirect = i_redirect_valid & (r_state != S_ERROR);
   assign w_misalign = w_redirect & (i_redirect_pc[1:0] != 2'b00);
   // a redirect drops the in-flight response and wins over a pop
   assign w_push     = r_inflight & ~w_redirect;
   assign w_fifo_pop = w_pop & ~w_redirect;

   // (count + inflight - pop) < DEPTH, rearranged to avoid underflow
   assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_lim  = {1'b0, DEPTH_C} + {{CW{1'b0}}, w_pop};
   assign w_room = (w_occ < w_lim);
   assign w_req  = (r_state == S_RUN) & ~i_halt_req & ~i_redirect_valid & w_room;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BOOT:   w_state_nxt = S_RUN;
         // a same-cycle redirect kills the in-flight fetch, so halt may proceed
         S_RUN:    if (i_halt_req && (!r_inflight || w_redirect)) w_state_nxt = S_HALTED;
         S_HALTED: if (!i_halt_req) w_state_nxt = S_RUN;
         default:  w_state_nxt = S_ERROR;
      endcase
      if (w_misalign) w_state_nxt = S_ERROR;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_misalign    <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_req;
         if (w_req) r_inflight_pc <= r_pc;
         if (w_redirect) r_pc <= i_redirect_pc;
         else if (w_req) r_pc <= r_pc + 32'd4;
         if (w_misalign) r_misalign <= 1'b1;
         if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push)     r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            if (w_fifo_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_fifo_pop};
         end
      end
   end

   // storage needs no reset: the outputs are masked while the FIFO is empty
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_instr[r_wr_ptr] <= i_imem_rdata;
         r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
      end
   end

   assign o_imem_req     = w_req;
   assign o_imem_addr    = r_pc;
   assign o_if_valid     = w_valid;
   assign o_if_instr     = w_valid ? r_mem_instr[r_rd_ptr] : '0;
   assign o_if_pc        = w_valid ? r_mem_pc[r_rd_ptr] : '0;
   assign o_halted       = (r_state == S_HALTED) | (r_state == S_ERROR);
   assign o_misalign_err = r_misalign;

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_stall;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_perf_fetched <= '0;
         r_perf_stall   <= '0;
      end else begin
         if (w_fifo_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
         if ((r_state == S_RUN) && !w_req && !i_halt_req) r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign o_perf_fetched = r_perf_fetched;
   assign o_perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl : self-checking bench for fetch_ctrl
//   Two instances share the control inputs: u_dut (RESET_PC=0) and u_dut_w
//   (RESET_PC=FFFF_FFF8, used to observe PC wrap-around). Each ROM returns
//   addr>>2, so ROM word[i]=i. Expected PCs are queued as stimulus is set up
//   and popped on every decode handshake.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_req, w_imem_req;
   logic [31:0] imem_addr, w_imem_addr;
   logic [31:0] imem_rdata = '0, w_imem_rdata = '0;
   logic        if_valid, w_if_valid;
   logic        if_ready;
   logic [31:0] if_instr, w_if_instr;
   logic [31:0] if_pc, w_if_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        halted, w_halted;
   logic        misalign_err, w_misalign_err;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
      .i_clk(clk), .i_rstn(rstn),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
      .o_if_valid(if_valid), .i_if_ready(if_ready),
      .o_if_instr(if_instr), .o_if_pc(if_pc),
      .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
      .i_halt_req(halt_req), .o_halted(halted), .o_misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
      , .o_perf_fetched(perf_fetched), .o_perf_stall(perf_stall)
`endif
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_w (
      .i_clk(clk), .i_rstn(rstn),
      .o_imem_req(w_imem_req), .o_imem_addr(w_imem_addr), .i_imem_rdata(w_imem_rdata),
      .o_if_valid(w_if_valid), .i_if_ready(if_ready),
      .o_if_instr(w_if_instr), .o_if_pc(w_if_pc),
      .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
      .i_halt_req(halt_req), .o_halted(w_halted), .o_misalign_err(w_misalign_err)
`ifdef FETCH_PERF_EN
      , .o_perf_fetched(w_perf_fetched), .o_perf_stall(w_perf_stall)
`endif
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   // synchronous ROMs: data one cycle after the request, garbage otherwise
   always @(posedge clk) begin
      imem_rdata   <= imem_req   ? rom_word(imem_addr)   : 32'hDEAD_BEEF;
      w_imem_rdata <= w_imem_req ? rom_word(w_imem_addr) : 32'hDEAD_BEEF;
   end

   // leaves the bench in cycle 0 (BOOT) with reset released
   task automatic do_reset();
      rstn = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; halt_req = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; halt_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || halted !== 1'b0 || misalign_err !== 1'b0 ||
          if_instr !== 32'h0 || if_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: req=%b valid=%b halted=%b mis=%b instr=%h pc=%h, want 0 0 0 0 0 0",
                  imem_req, if_valid, halted, misalign_err, if_instr, if_pc);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
         errors++;
         $display("FAIL reset_perf: fetched=%0d stall=%0d, want 0 0", perf_fetched, perf_stall);
      end
`endif
      // run into steady state, then reset with a fetch in flight
      @(posedge clk); #1 rstn = 1'b1; if_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_midop: valid=%b req=%b pc=%h, want 0 0 0", if_valid, imem_req, if_pc);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (if_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_stale: valid=%b, want 0", if_valid);
      end
   endtask

   task automatic test_stream();
      int hs = 0;
      logic [31:0] e;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(32'(4 * i));
      if_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: req=%b, want 0", imem_req); end
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (cyc == 1) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
               errors++; $display("FAIL first_req: req=%b addr=%h, want 1 0", imem_req, imem_addr);
            end
         end
         if (cyc == 2) begin
            checks++;
            if (if_valid !== 1'b0) begin errors++; $display("FAIL early_valid: valid=%b, want 0", if_valid); end
         end
         if (cyc >= 3) begin
            checks++;
            if (if_valid !== 1'b1) begin
               errors++; $display("FAIL stream_valid: cycle %0d valid=%b, want 1", cyc, if_valid);
            end
         end
         if (if_valid && if_ready) begin
            hs++; checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (if_pc !== e || if_instr !== rom_word(e)) begin
               errors++; $display("FAIL stream_data: pc=%h instr=%h, want %h %h", if_pc, if_instr, e, rom_word(e));
            end
         end
      end
      checks++;
      if (hs != 12) begin errors++; $display("FAIL stream_count: got %0d, want 12", hs); end
   endtask

   task automatic test_backpressure();
      int hs = 0;
      logic [31:0] e;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(posedge clk); #1 if_ready = (cyc >= 9);
         @(negedge clk);
         if (cyc >= 3 && cyc <= 8) begin
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
               errors++;
               $display("FAIL bp_hold: cycle %0d req=%b valid=%b pc=%h, want 0 1 0", cyc, imem_req, if_valid, if_pc);
            end
         end
         if (cyc == 9) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
               errors++; $display("FAIL bp_resume: req=%b addr=%h, want 1 8", imem_req, imem_addr);
            end
`ifdef FETCH_PERF_EN
            checks++;
            if (perf_stall !== 32'd6) begin errors++; $display("FAIL bp_stall: got %0d, want 6", perf_stall); end
`endif
         end
         if (if_valid && if_ready) begin
            hs++; checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (if_pc !== e || if_instr !== rom_word(e)) begin
               errors++; $display("FAIL bp_data: pc=%h instr=%h, want %h %h", if_pc, if_instr, e, rom_word(e));
            end
         end
      end
      checks++;
      if (hs != 6) begin errors++; $display("FAIL bp_count: got %0d, want 6", hs); end
   endtask

   task automatic test_redirect();
      int hs = 0;
      logic [31:0] e;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      if_ready = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(posedge clk); #1;
         redirect_valid = (cyc == 5);
         redirect_pc    = 32'h40;
         if_ready       = (cyc != 5);
         if (cyc == 5) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + 32'(4 * i));
         end
         @(negedge clk);
         if (cyc == 5) begin
            checks++;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: req=%b, want 0", imem_req); end
         end
         if (cyc == 6) begin
            checks++;
            if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
               errors++;
               $display("FAIL redir_flush: valid=%b req=%b addr=%h, want 0 1 40", if_valid, imem_req, imem_addr);
            end
         end
         if (cyc == 7) begin
            checks++;
            if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_stale: valid=%b, want 0", if_valid); end
         end
         if (if_valid && if_ready) begin
            if (cyc > 5) hs++;
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (if_pc !== e || if_instr !== rom_word(e)) begin
               errors++; $display("FAIL redir_data: pc=%h instr=%h, want %h %h", if_pc, if_instr, e, rom_word(e));
            end
         end
      end
      checks++;
      if (hs != 5) begin errors++; $display("FAIL redir_count: got %0d, want 5", hs); end
   endtask

   task automatic test_halt();
      int hs = 0;
      bit seen = 1'b0;
      logic [31:0] e;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back(32'(4 * i));
      if_ready = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1 halt_req = (cyc >= 6 && cyc <= 9);
         @(negedge clk);
         if (cyc >= 6 && cyc <= 9) begin
            checks++;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req_off: cycle %0d req=%b, want 0", cyc, imem_req); end
         end
         if (cyc == 6) begin
            checks++;
            if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: halted=%b, want 0", halted); end
         end
         if (cyc == 9) begin
            checks++;
            if (halted !== 1'b1) begin errors++; $display("FAIL halt_state: halted=%b, want 1", halted); end
         end
         if (cyc >= 10 && cyc <= 15 && !seen && imem_req) begin
            seen = 1'b1; checks++;
            if (imem_addr !== 32'h14) begin errors++; $display("FAIL halt_resume: addr=%h, want 14", imem_addr); end
         end
         if (if_valid && if_ready) begin
            hs++; checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (if_pc !== e || if_instr !== rom_word(e)) begin
               errors++; $display("FAIL halt_data: pc=%h instr=%h, want %h %h", if_pc, if_instr, e, rom_word(e));
            end
         end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL halt_timeout: no request after halt released, want one by cycle 15"); end
      checks++;
      if (hs < 10) begin errors++; $display("FAIL halt_count: got %0d, want >=10", hs); end
   endtask

   task automatic test_wrap();
      int hs = 0;
      logic [31:0] e;
      logic [31:0] wq [$];
      do_reset();
      wq.push_back(32'hFFFF_FFF8); wq.push_back(32'hFFFF_FFFC);
      for (int i = 0; i < 4; i++) wq.push_back(32'(4 * i));
      if_ready = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (w_if_valid && if_ready) begin
            hs++; checks++;
            e = (wq.size() != 0) ? wq.pop_front() : 32'h1234_5677;
            if (w_if_pc !== e || w_if_instr !== rom_word(e)) begin
               errors++; $display("FAIL wrap_data: pc=%h instr=%h, want %h %h", w_if_pc, w_if_instr, e, rom_word(e));
            end
         end
      end
      checks++;
      if (hs != 6) begin errors++; $display("FAIL wrap_count: got %0d, want 6", hs); end
   endtask

   task automatic test_misalign();
      int hs = 0;
      do_reset();
      if_ready = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(posedge clk); #1;
         redirect_valid = (cyc == 6);
         redirect_pc    = 32'h42;
         if_ready       = (cyc != 6);
         @(negedge clk);
         if (if_valid && if_ready) hs++;
         if (cyc >= 7) begin
            checks++;
            if (misalign_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
               errors++;
               $display("FAIL misalign: cycle %0d mis=%b halted=%b req=%b valid=%b, want 1 1 0 0",
                        cyc, misalign_err, halted, imem_req, if_valid);
            end
         end
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== 32'(hs)) begin
         errors++; $display("FAIL perf_fetched: got %0d, want %0d", perf_fetched, hs);
      end
`endif
      do_reset();
      @(negedge clk);
      checks++;
      if (misalign_err !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("FAIL misalign_clear: mis=%b halted=%b, want 0 0", misalign_err, halted);
      end
   endtask

   initial begin
      rstn = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
